sipo_deserializer: RTL and testbench

Serial-to-parallel receiver for the team's single-bit serial data path. It is the receive end of a serial stream such as the one produced at a shift register's serial output. It collects strobed serial bits into WIDTH-bit words, framed by a start marker on the first bit. Completed words are presented on a valid/ready output port with overrun detection, feeding parallel consumers (FIFOs, register files).

---
 rtl/sipo_deserializer_if.sv | 24 ++
 rtl/sipo_deserializer.sv | 135 +++++++++++++
 tb/tb_sipo_deserializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial-in / word-out port bundle for sipo_deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output ser_in, ser_valid, frame_start, dout_ready,
        input  dout, dout_valid, busy, overrun, parity_err
    );

    modport slave (
        input  ser_in, ser_valid, frame_start, dout_ready,
        output dout, dout_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - framed serial-to-parallel receiver with valid/ready output and overrun flag
// Optional even-parity bit after each word: define SIPO_DESERIALIZER_PARITY_CHECK_EN.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    sipo_deserializer_if.slave sipo_if
);
    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             word_done;
    logic             load;
    logic [CW-1:0]    bit_idx;
    logic [CW-1:0]    bit_pos;

    // A framed bit is always index 0, whatever the counter holds.
    assign bit_idx = sipo_if.frame_start ? '0 : cnt_q;
    assign bit_pos = (LSB_FIRST != 0) ? bit_idx : (LAST_IDX - bit_idx);

`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    logic par_bad;
    logic par_err_q, par_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
        par_bad   = 1'b0;
`endif
        if (sipo_if.ser_valid) begin
            if (sipo_if.frame_start) begin
                shift_d          = '0;
                shift_d[bit_pos] = sipo_if.ser_in;
                cnt_d            = CW'(1);
                state_d          = SHIFT;
            end else begin
                unique case (state_q)
                    SHIFT: begin
                        shift_d[bit_pos] = sipo_if.ser_in;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d     = '0;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
                            state_d   = PARITY;
`else
                            state_d   = IDLE;
                            word_done = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
                    PARITY: begin
                        state_d   = IDLE;
                        word_done = 1'b1;
                        par_bad   = ^{shift_q, sipo_if.ser_in};
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // A completed word replaces the presented one only if that one is leaving this cycle.
    assign load = word_done && (!dout_valid_q || sipo_if.dout_ready);

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        if (load) begin
            dout_d       = shift_d;
            dout_valid_d = 1'b1;
        end else if (word_done) begin
            overrun_d = 1'b1;
        end else if (dout_valid_q && sipo_if.dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    assign par_err_d = load ? par_bad : par_err_q;

    always_ff @(posedge clk) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end

    assign sipo_if.parity_err = par_err_q;
`else
    assign sipo_if.parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sipo_if.dout       = dout_q;
    assign sipo_if.dout_valid = dout_valid_q;
    assign sipo_if.overrun    = overrun_q;
    assign sipo_if.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer, LSB-first and MSB-first instances
module tb_sipo_deserializer;
    localparam int W = 8;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_in = 1'b0, ser_valid = 1'b0, frame_start = 1'b0, dout_ready = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    sipo_deserializer_if #(.WIDTH(W)) if_l ();
    sipo_deserializer_if #(.WIDTH(W)) if_m ();

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (.clk(clk), .rst(rst), .sipo_if(if_l.slave));
    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(0)) dut_m (.clk(clk), .rst(rst), .sipo_if(if_m.slave));

    assign if_l.ser_in = ser_in;
    assign if_l.ser_valid = ser_valid;
    assign if_l.frame_start = frame_start;
    assign if_l.dout_ready = dout_ready;
    assign if_m.ser_in = ser_in;
    assign if_m.ser_valid = ser_valid;
    assign if_m.frame_start = frame_start;
    assign if_m.dout_ready = dout_ready;

    always #5 clk = ~clk;

    // Reference model: a list of bits collected since the last framed bit.
    bit         m_bits[$];
    bit         m_active = 0, m_valid = 0, m_over = 0, m_perr = 0;
    logic [W-1:0] m_dl = '0, m_dm = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit           done;
        bit           p;
        logic [W-1:0] wl, wm;
        done = 0;
        if (rst) begin
            m_bits.delete();
            m_active = 0; m_valid = 0; m_over = 0; m_perr = 0; m_dl = '0; m_dm = '0;
            return;
        end
        if (ser_valid) begin
            if (frame_start) begin
                m_bits.delete();
                m_bits.push_back(ser_in);
                m_active = 1;
            end else if (m_active) begin
                m_bits.push_back(ser_in);
            end
            if (m_active && m_bits.size() == NB) begin
                done = 1;
                m_active = 0;
            end
        end
        if (done) begin
            wl = '0; wm = '0; p = 0;
            for (int k = 0; k < NB; k++) begin
                if (k < W) begin
                    wl = wl + (W'(m_bits[k]) << k);
                    wm = wm + (W'(m_bits[k]) << (W - 1 - k));
                end
                p = p ^ m_bits[k];
            end
            if (!m_valid || dout_ready) begin
                m_valid = 1; m_dl = wl; m_dm = wm; m_perr = (NB > W) ? p : 1'b0;
            end else begin
                m_over = 1;
            end
        end else if (m_valid && dout_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("valid_l", 32'(if_l.dout_valid), 32'(m_valid));
        check("valid_m", 32'(if_m.dout_valid), 32'(m_valid));
        check("dout_l", 32'(if_l.dout), 32'(m_dl));
        check("dout_m", 32'(if_m.dout), 32'(m_dm));
        check("busy_l", 32'(if_l.busy), 32'(m_active));
        check("busy_m", 32'(if_m.busy), 32'(m_active));
        check("overrun_l", 32'(if_l.overrun), 32'(m_over));
        check("overrun_m", 32'(if_m.overrun), 32'(m_over));
        check("perr_l", 32'(if_l.parity_err), 32'(m_perr));
        check("perr_m", 32'(if_m.parity_err), 32'(m_perr));
    endtask

    // seq[i] is the i-th bit on the wire; under parity an even-parity bit follows, optionally flipped.
    task automatic send_word(input logic [W-1:0] seq, input int gap, input bit pflip);
        for (int i = 0; i < NB; i++) begin
            ser_valid = 1'b1;
            frame_start = (i == 0);
            ser_in = (i < W) ? seq[i] : ((^seq) ^ pflip);
            tick();
            check("busy_bit", 32'(if_l.busy), 32'(i < NB - 1));
            ser_valid = 1'b0;
            frame_start = 1'b0;
            if (i < NB - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", 32'(if_m.busy), 32'd1);
                end
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] seq;
        int           gap;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_m;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{seq: 8'hA5, gap: 0, exp_l: 8'hA5, exp_m: 8'hA5};
        vecs[1] = '{seq: 8'hA5, gap: 3, exp_l: 8'hA5, exp_m: 8'hA5};
        vecs[2] = '{seq: 8'h83, gap: 0, exp_l: 8'h83, exp_m: 8'hC1};
        vecs[3] = '{seq: 8'h01, gap: 1, exp_l: 8'h01, exp_m: 8'h80};
        vecs[4] = '{seq: 8'hF0, gap: 2, exp_l: 8'hF0, exp_m: 8'h0F};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(if_l.dout_valid), 32'd0);
        check("rst_dout", 32'(if_l.dout), 32'd0);
        check("rst_busy", 32'(if_l.busy), 32'd0);
        check("rst_overrun", 32'(if_l.overrun), 32'd0);
        check("rst_perr", 32'(if_l.parity_err), 32'd0);

        dout_ready = 1'b1;
        foreach (vecs[v]) begin
            ser_valid = 1'b1; frame_start = 1'b0; ser_in = 1'b1;
            tick();
            check("stray_busy", 32'(if_l.busy), 32'd0);
            ser_valid = 1'b0;
            send_word(vecs[v].seq, vecs[v].gap, 1'b0);
            check("vec_valid", 32'(if_l.dout_valid), 32'd1);
            check("vec_dout_l", 32'(if_l.dout), 32'(vecs[v].exp_l));
            check("vec_dout_m", 32'(if_m.dout), 32'(vecs[v].exp_m));
            check("vec_perr", 32'(if_l.parity_err), 32'd0);
            tick();
            check("vec_valid_drop", 32'(if_l.dout_valid), 32'd0);
        end

        // Overrun: second word dropped while first is held.
        dout_ready = 1'b0;
        send_word(8'h3C, 0, 1'b0);
        check("ovr_first", 32'(if_l.dout), 32'h3C);
        check("ovr_flag0", 32'(if_l.overrun), 32'd0);
        send_word(8'hC3, 0, 1'b0);
        check("ovr_hold", 32'(if_l.dout), 32'h3C);
        check("ovr_hold_m", 32'(if_m.dout), 32'h3C);
        check("ovr_flag1", 32'(if_l.overrun), 32'd1);
        check("ovr_valid", 32'(if_l.dout_valid), 32'd1);
        dout_ready = 1'b1;
        tick();
        check("ovr_drain", 32'(if_l.dout_valid), 32'd0);
        repeat (3) tick();
        check("ovr_sticky", 32'(if_l.overrun), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovr_cleared", 32'(if_l.overrun), 32'd0);

        // Resync after a partial word.
        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1; frame_start = (i == 0); ser_in = 1'($urandom_range(0, 1));
            tick();
        end
        send_word(8'h5A, 0, 1'b0);
        check("resync_dout", 32'(if_l.dout), 32'h5A);
        check("resync_valid", 32'(if_l.dout_valid), 32'd1);
        check("resync_ovr", 32'(if_l.overrun), 32'd0);
        tick();

        // Reset mid-word, then a clean word.
        for (int i = 0; i < 5; i++) begin
            ser_valid = 1'b1; frame_start = (i == 0); ser_in = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(if_l.busy), 32'd0);
        check("midrst_dout", 32'(if_l.dout), 32'd0);
        check("midrst_valid", 32'(if_l.dout_valid), 32'd0);
        send_word(8'h83, 0, 1'b0);
        check("post_rst_l", 32'(if_l.dout), 32'h83);
        check("post_rst_m", 32'(if_m.dout), 32'hC1);
        tick();

        // Back-to-back words with no idle cycle.
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h3C, 0, 1'b0);
        check("b2b_valid", 32'(if_l.dout_valid), 32'd1);
        check("b2b_dout", 32'(if_l.dout), 32'h3C);
        tick();

        // Parity: correct bit, then flipped bit.
        send_word(8'hA5, 0, 1'b0);
        check("par_ok", 32'(if_l.parity_err), 32'd0);
        tick();
        send_word(8'hA5, 0, 1'b1);
        check("par_flip", 32'(if_l.parity_err), 32'(NB > W));
        check("par_valid", 32'(if_l.dout_valid), 32'd1);
        tick();

        for (int c = 0; c < 3000; c++) begin
            ser_valid = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 9) == 0);
            ser_in = 1'($urandom_range(0, 1));
            dout_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
